serial_mag_comparator: RTL and testbench

- Sequential, bit-serial magnitude comparator for two WIDTH-bit operands. It processes one bit pair per clock, LSB first.
- Functionally it is the clocked counterpart of the ripple 1-bit comparator chain. A per-bit "differ → take this bit's verdict, equal → keep carried verdict" rule replaces the N-stage combinational cascade with one stage iterated N times.
- Sits between operand registers and control logic where area matters more than latency. Start/done handshake; supports unsigned and two's-complement compare.

---
 rtl/serial_mag_comparator_if.sv | 25 ++
 rtl/serial_mag_comparator.sv | 105 ++++++++++
 tb/tb_serial_mag_comparator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_mag_comparator_if.sv
// Operand/result handshake bundle for the bit-serial magnitude comparator.
// The master drives the operands and start; the slave returns status and verdict.
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, lt, eq, gt
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, lt, eq, gt
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: one bit pair per clock, LSB first, with a
// carried verdict that higher bits override. Unsigned or two's-complement.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_mag_comparator_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

    state_t           state, state_nxt;
    rel_t             rel, rel_nxt;
    logic [WIDTH-1:0] sa, sa_nxt, sb, sb_nxt;
    logic             mode, mode_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy, busy_nxt, done, done_nxt;
    logic             lt, lt_nxt, eq, eq_nxt, gt, gt_nxt;
    logic             msb;

    assign msb = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rel   <= REL_EQ;
            sa    <= '0;
            sb    <= '0;
            mode  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
        end else begin
            state <= state_nxt;
            rel   <= rel_nxt;
            sa    <= sa_nxt;
            sb    <= sb_nxt;
            mode  <= mode_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            lt    <= lt_nxt;
            eq    <= eq_nxt;
            gt    <= gt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rel_nxt   = rel;
        sa_nxt    = sa;
        sb_nxt    = sb;
        mode_nxt  = mode;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        lt_nxt    = lt;
        eq_nxt    = eq;
        gt_nxt    = gt;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    sa_nxt    = bus.a;
                    sb_nxt    = bus.b;
                    mode_nxt  = bus.signed_mode;
                    rel_nxt   = REL_EQ;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // A differing sign bit in signed mode means the operand with a 1 is negative.
                if (sa[0] != sb[0]) begin
                    if (msb && mode) rel_nxt = sa[0] ? REL_LT : REL_GT;
                    else             rel_nxt = sa[0] ? REL_GT : REL_LT;
                end
                sa_nxt  = sa >> 1;
                sb_nxt  = sb >> 1;
                cnt_nxt = cnt + CNT_W'(1);
                if (msb) begin
                    lt_nxt    = (rel_nxt == REL_LT);
                    eq_nxt    = (rel_nxt == REL_EQ);
                    gt_nxt    = (rel_nxt == REL_GT);
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.lt   = lt;
    assign bus.eq   = eq;
    assign bus.gt   = gt;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator with an arithmetic reference model
// checked every cycle, plus hand-computed expectations per vector.
module tb_serial_mag_comparator;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_mag_comparator_if #(.WIDTH(W)) bus ();
    serial_mag_comparator #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result from plain arithmetic, timing from an edge countdown.
    logic m_busy, m_done;
    logic [2:0] m_res;
    logic [2:0] m_pend;
    int m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_res = 3'b000; m_pend = 3'b000; m_left = 0;
        end else if (!m_busy && bus.start) begin
            if (bus.signed_mode)
                m_pend = ($signed(bus.a) < $signed(bus.b)) ? 3'b100 :
                         ($signed(bus.a) > $signed(bus.b)) ? 3'b001 : 3'b010;
            else
                m_pend = (bus.a < bus.b) ? 3'b100 : (bus.a > bus.b) ? 3'b001 : 3'b010;
            m_busy = 1; m_done = 0; m_left = W;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_res = m_pend;
            end
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        chk("model_busy", {31'd0, bus.busy}, {31'd0, m_busy});
        chk("model_done", {31'd0, bus.done}, {31'd0, m_done});
        chk("model_ltgteq", {29'd0, bus.lt, bus.eq, bus.gt}, {29'd0, m_res});
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.done && cyc < 40);
        if (!bus.done) chk("done_timeout", 0, 1);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        bus.a = a; bus.b = b; bus.signed_mode = sm; bus.start = 1'b1;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, input logic [2:0] exp);
        int cyc;
        drive(a, b, sm);
        tick();
        bus.start = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.signed_mode = ~sm;
        chk({name, "_busy"}, {31'd0, bus.busy}, 1);
        wait_done(cyc);
        chk({name, "_latency"}, cyc, W);
        chk({name, "_res"}, {29'd0, bus.lt, bus.eq, bus.gt}, {29'd0, exp});
        tick();
        chk({name, "_done_drop"}, {31'd0, bus.done}, 0);
        chk({name, "_hold"}, {29'd0, bus.lt, bus.eq, bus.gt}, {29'd0, exp});
    endtask

    initial begin
        int cyc, ndone;
        bus.start = 0; bus.a = '0; bus.b = '0; bus.signed_mode = 0;
        #12;
        chk("reset_out", {27'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt}, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        run_op("eq5a",     8'h5A, 8'h5A, 1'b0, 3'b010);
        run_op("u80_7f",   8'h80, 8'h7F, 1'b0, 3'b001);
        run_op("s80_7f",   8'h80, 8'h7F, 1'b1, 3'b100);
        run_op("sff_fe",   8'hFF, 8'hFE, 1'b1, 3'b001);
        run_op("u0f_f0",   8'h0F, 8'hF0, 1'b0, 3'b100);
        run_op("u01_00",   8'h01, 8'h00, 1'b0, 3'b001);
        run_op("s01_ff",   8'h01, 8'hFF, 1'b1, 3'b001);

        // start pulsed while busy must be ignored
        drive(8'h10, 8'h20, 1'b0);
        tick(); bus.start = 0;
        tick(); tick();
        drive(8'hFF, 8'h00, 1'b0);
        tick(); bus.start = 0; bus.a = 8'hAA; bus.b = 8'h55;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) begin
                ndone++;
                chk("busyprot_res", {29'd0, bus.lt, bus.eq, bus.gt}, 3'b100);
            end
        end
        chk("busyprot_ndone", ndone, 1);

        // reset mid-operation
        drive(8'h33, 8'h22, 1'b0);
        tick(); bus.start = 0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out", {27'd0, bus.busy, bus.done, bus.lt, bus.eq, bus.gt}, 0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        chk("abort_ndone", ndone, 0);
        run_op("after_rst", 8'h33, 8'h22, 1'b0, 3'b001);

        // back-to-back: new start held in the done cycle
        drive(8'd3, 8'd3, 1'b0);
        tick(); bus.start = 0;
        wait_done(cyc);
        chk("b2b_first", {29'd0, bus.lt, bus.eq, bus.gt}, 3'b010);
        drive(8'd9, 8'd4, 1'b0);
        tick(); bus.start = 0; bus.a = 8'd0; bus.b = 8'd200;
        chk("b2b_busy", {31'd0, bus.busy}, 1);
        chk("b2b_hold", {29'd0, bus.lt, bus.eq, bus.gt}, 3'b010);
        wait_done(cyc);
        chk("b2b_latency", cyc, W);
        chk("b2b_second", {29'd0, bus.lt, bus.eq, bus.gt}, 3'b001);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
